// File: rtl/aes_pkg.sv
// Shared AES helpers: round-sequencer state encoding, column/byte indexing and
// the ShiftRows / InvShiftRows byte permutations on a 128-bit column-major state.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SB   = 2'd1,
    MC   = 2'd2,
    FIN  = 2'd3
  } roundState_t;

  localparam int NumCols = 4;
  localparam int NumRows = 4;

  // Byte (row, col) lives at bits 32*col + 8*row within the state.
  function automatic int byteLsb(input int row, input int col);
    return 32 * col + 8 * row;
  endfunction

  function automatic logic [31:0] getCol(input logic [127:0] s, input logic [1:0] c);
    return s[32*c +: 32];
  endfunction

  function automatic logic [127:0] setCol(input logic [127:0] s, input logic [1:0] c,
                                          input logic [31:0] w);
    logic [127:0] r;
    r = s;
    r[32*c +: 32] = w;
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < NumCols; c++) begin
      for (int row = 0; row < NumRows; row++) begin
        r[byteLsb(row, c) +: 8] = s[byteLsb(row, (c + row) % NumCols) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < NumCols; c++) begin
      for (int row = 0; row < NumRows; row++) begin
        r[byteLsb(row, c) +: 8] = s[byteLsb(row, (c + NumCols - row) % NumCols) +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_seq.sv
// Sequences one AES round through an external SubBytes/MixColumns FU, doing
// ShiftRows/InvShiftRows and AddRoundKey locally on the working state.
module aes_round_seq
  import aes_pkg::*;
#(
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         start,
  input  logic         dec,
  input  logic         last,
  input  logic [127:0] state_in,
  input  logic [127:0] rkey,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out,
  output logic         fu_valid,
  output logic         fu_dec,
  output logic         fu_mix,
  output logic [31:0]  fu_rs1,
  input  logic         fu_ready,
  input  logic [31:0]  fu_rd
);

  roundState_t  state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic [127:0] key_q, key_d;
  logic         dec_q, dec_d;
  logic         last_q, last_d;
  logic [127:0] out_q, out_d;
  logic [127:0] merged;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      last_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      last_q  <= last_d;
      out_q   <= out_d;
    end
  end

  // The last column's FU result is merged before the row permutation / key add.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    work_d   = work_q;
    key_d    = key_q;
    dec_d    = dec_q;
    last_d   = last_q;
    out_d    = out_q;
    merged   = setCol(work_q, col_q, fu_rd);
    fu_valid = 1'b0;
    fu_mix   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = state_in;
          key_d   = rkey;
          dec_d   = dec & DECRYPT_EN;
          last_d  = last;
          col_d   = 2'd0;
          state_d = SB;
        end
      end
      SB: begin
        fu_valid = 1'b1;
        if (fu_ready) begin
          col_d  = col_q + 2'd1;
          work_d = merged;
          if (col_q == 2'd3) begin
            if (dec_q) begin
              work_d = inv_shift_rows(merged) ^ key_q;
            end else if (last_q) begin
              work_d = shift_rows(merged) ^ key_q;
            end else begin
              work_d = shift_rows(merged);
            end
            if (last_q) begin
              out_d   = work_d;
              state_d = FIN;
            end else begin
              state_d = MC;
            end
          end
        end
      end
      MC: begin
        fu_valid = 1'b1;
        fu_mix   = 1'b1;
        if (fu_ready) begin
          col_d  = col_q + 2'd1;
          work_d = merged;
          if (col_q == 2'd3) begin
            // Decrypt already added its key before InvMixColumns.
            if (!dec_q) begin
              work_d = merged ^ key_q;
            end
            out_d   = work_d;
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign state_out = out_q;
  assign fu_dec    = dec_q;
  assign fu_rs1    = getCol(work_q, col_q);

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: a behavioural AES FU model answers the
// sequencer and rounds are checked against FIPS-197 vectors.
module tb_aes_round_seq;

  logic         g_clk = 1'b0;
  logic         g_resetn;
  logic         start, startB;
  logic         dec, last;
  logic [127:0] state_in, rkey;
  logic         busy, done, fu_valid, fu_dec, fu_mix, fu_ready;
  logic [127:0] state_out;
  logic [31:0]  fu_rs1, fu_rd;
  logic         busyB, doneB, fuValidB, fuDecB, fuMixB, fuReadyB;
  logic [127:0] stateOutB;
  logic [31:0]  fuRs1B, fuRdB;

  int checks = 0;
  int passes = 0;
  int cnt = 0;
  int curDelay = 0;
  bit randMode = 1'b0;
  bit junkReady = 1'b0;
  int hsCount = 0, mixCount = 0, decZeroCount = 0, doneCount = 0, stableErr = 0;
  int decOneB = 0;
  bit stPending = 1'b0;
  logic [31:0] stRs1;
  logic stMix, stDec;

  always #5 g_clk = ~g_clk;

  aes_round_seq #(.DECRYPT_EN(1'b1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .start(start), .dec(dec), .last(last),
    .state_in(state_in), .rkey(rkey), .busy(busy), .done(done), .state_out(state_out),
    .fu_valid(fu_valid), .fu_dec(fu_dec), .fu_mix(fu_mix), .fu_rs1(fu_rs1),
    .fu_ready(fu_ready), .fu_rd(fu_rd)
  );

  aes_round_seq #(.DECRYPT_EN(1'b0)) dutEnc (
    .g_clk(g_clk), .g_resetn(g_resetn), .start(startB), .dec(dec), .last(last),
    .state_in(state_in), .rkey(rkey), .busy(busyB), .done(doneB), .state_out(stateOutB),
    .fu_valid(fuValidB), .fu_dec(fuDecB), .fu_mix(fuMixB), .fu_rs1(fuRs1B),
    .fu_ready(fuReadyB), .fu_rd(fuRdB)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 254; i++) p = gmul(p, a);
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] fuCompute(input logic [31:0] rs1, input logic mix,
                                            input logic d);
    logic [7:0] a [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = rs1[8*i +: 8];
    for (int i = 0; i < 4; i++) begin
      if (!mix) r[8*i +: 8] = d ? invSbox(a[i]) : sbox(a[i]);
      else if (!d)
        r[8*i +: 8] = gmul(a[i], 8'h02) ^ gmul(a[(i+1)%4], 8'h03) ^ a[(i+2)%4] ^ a[(i+3)%4];
      else
        r[8*i +: 8] = gmul(a[i], 8'h0e) ^ gmul(a[(i+1)%4], 8'h0b)
                    ^ gmul(a[(i+2)%4], 8'h0d) ^ gmul(a[(i+3)%4], 8'h09);
    end
    return r;
  endfunction

  // FIPS-197 hex strings list byte 0 first; the DUT keeps byte 0 in bits 7:0.
  function automatic logic [127:0] fipsToState(input logic [127:0] f);
    logic [127:0] s;
    for (int i = 0; i < 16; i++) s[8*i +: 8] = f[127-8*i -: 8];
    return s;
  endfunction

  // Single-SBox FU timing: SubBytes answers 4 cycles after valid, MixColumns at once.
  assign fu_ready = (fu_valid && (cnt == (randMode ? curDelay : (fu_mix ? 0 : 4)))) || junkReady;
  assign fu_rd    = fuCompute(fu_rs1, fu_mix, fu_dec);
  assign fuReadyB = fuValidB;
  assign fuRdB    = fuCompute(fuRs1B, fuMixB, fuDecB);

  always @(posedge g_clk) begin
    if (!fu_valid) cnt <= 0;
    else if (fu_ready) begin
      cnt <= 0;
      curDelay <= int'($urandom_range(0, 7));
    end else cnt <= cnt + 1;
  end

  always @(negedge g_clk) begin
    if (g_resetn) begin
      if (fu_valid && fu_ready) hsCount <= hsCount + 1;
      if (fu_valid && fu_mix) mixCount <= mixCount + 1;
      if (fu_valid && !fu_dec) decZeroCount <= decZeroCount + 1;
      if (done) doneCount <= doneCount + 1;
      if (fuValidB && fuDecB) decOneB <= decOneB + 1;
      if (stPending && (fu_valid !== 1'b1 || fu_rs1 !== stRs1 || fu_mix !== stMix || fu_dec !== stDec))
        stableErr <= stableErr + 1;
    end
    stPending <= g_resetn && fu_valid && !fu_ready;
    stRs1 <= fu_rs1;
    stMix <= fu_mix;
    stDec <= fu_dec;
  end

  task automatic runRound(input logic [127:0] stIn, input logic [127:0] key, input logic d,
                          input logic l, input bit spam, output logic [127:0] res, output int cyc);
    logic [127:0] prevOut;
    bit seen, changed;
    @(negedge g_clk);
    state_in = stIn; rkey = key; dec = d; last = l; start = 1'b1;
    prevOut = state_out;
    @(posedge g_clk); #1;
    cyc = 1; seen = 0; changed = 0;
    if (spam) state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    else start = 1'b0;
    while (!seen && cyc < 300) begin
      if (done) seen = 1;
      else begin
        if (state_out !== prevOut) changed = 1;
        @(posedge g_clk); #1;
        cyc++;
        if (spam) state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    res = state_out;
    checks++;
    if (!seen) $display("[TB] FAIL round_complete done=%0b want 1 within 300 cycles", done);
    else passes++;
    @(posedge g_clk); #1;
    start = 1'b0;
    if (spam) begin
      checks++;
      if (busy !== 1'b0) $display("[TB] FAIL start_in_fin busy=%0b want 0", busy);
      else passes++;
      checks++;
      if (changed) $display("[TB] FAIL out_held changed=%0b want 0", changed);
      else passes++;
    end
  endtask

  task automatic test_reset();
    g_resetn = 1'b0; start = 0; startB = 0; dec = 0; last = 0; state_in = '0; rkey = '0;
    repeat (3) @(posedge g_clk);
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy got %0b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rst_done got %0b want 0", done); else passes++;
    checks++; if (fu_valid !== 1'b0) $display("[TB] FAIL rst_valid got %0b want 0", fu_valid); else passes++;
    checks++; if (fu_mix !== 1'b0) $display("[TB] FAIL rst_mix got %0b want 0", fu_mix); else passes++;
    checks++; if (fu_dec !== 1'b0) $display("[TB] FAIL rst_dec got %0b want 0", fu_dec); else passes++;
    checks++; if (state_out !== '0) $display("[TB] FAIL rst_out got %h want 0", state_out); else passes++;
    g_resetn = 1'b1;
  endtask

  task automatic test_encrypt();
    logic [127:0] res, exp;
    int cyc, hs0;
    hs0 = hsCount;
    exp = fipsToState(128'ha49c7ff2689f352b6b5bea43026a5049);
    runRound(fipsToState(128'h193de3bea0f4e22b9ac68d2ae9f84808),
             fipsToState(128'ha0fafe1788542cb123a339392a6c7605), 1'b0, 1'b0, 1'b0, res, cyc);
    checks++; if (res !== exp) $display("[TB] FAIL enc_out got %h want %h", res, exp); else passes++;
    checks++; if (cyc !== 25) $display("[TB] FAIL enc_latency got %0d want 25", cyc); else passes++;
    checks++; if (hsCount - hs0 !== 8) $display("[TB] FAIL enc_handshakes got %0d want 8", hsCount - hs0); else passes++;
  endtask

  task automatic test_encrypt_last();
    logic [127:0] res, exp;
    int cyc, mix0;
    mix0 = mixCount;
    exp = fipsToState(128'h3925841d02dc09fbdc118597196a0b32);
    runRound(fipsToState(128'heb40f21e592e38848ba113e71bc342d2),
             fipsToState(128'hd014f9a8c9ee2589e13f0cc8b6630ca6), 1'b0, 1'b1, 1'b0, res, cyc);
    checks++; if (res !== exp) $display("[TB] FAIL enc_last_out got %h want %h", res, exp); else passes++;
    checks++; if (cyc !== 21) $display("[TB] FAIL enc_last_latency got %0d want 21", cyc); else passes++;
    checks++; if (mixCount - mix0 !== 0) $display("[TB] FAIL enc_last_mix got %0d want 0", mixCount - mix0); else passes++;
  endtask

  task automatic test_decrypt_last();
    logic [127:0] res, exp;
    int cyc, dz0;
    dz0 = decZeroCount;
    exp = fipsToState(128'heb40f21e592e38848ba113e71bc342d2);
    runRound(fipsToState(128'he9317db5cb322c723d2e895faf090794), '0, 1'b1, 1'b1, 1'b0, res, cyc);
    checks++; if (res !== exp) $display("[TB] FAIL dec_last_out got %h want %h", res, exp); else passes++;
    checks++; if (decZeroCount - dz0 !== 0) $display("[TB] FAIL dec_last_fu_dec low cycles %0d want 0", decZeroCount - dz0); else passes++;
  endtask

  task automatic test_decrypt_zero();
    logic [127:0] res;
    int cyc;
    runRound('0, '0, 1'b1, 1'b0, 1'b0, res, cyc);
    checks++; if (res !== {16{8'h52}}) $display("[TB] FAIL dec_zero_out got %h want all 52", res); else passes++;
  endtask

  task automatic test_encrypt_zero();
    logic [127:0] res;
    int cyc;
    runRound('0, '0, 1'b0, 1'b0, 1'b0, res, cyc);
    checks++; if (res !== {16{8'h63}}) $display("[TB] FAIL enc_zero_out got %h want all 63", res); else passes++;
  endtask

  task automatic test_protocol();
    logic [127:0] res, exp;
    int cyc, hs0, se0;
    hs0 = hsCount; se0 = stableErr;
    randMode = 1'b1;
    exp = fipsToState(128'ha49c7ff2689f352b6b5bea43026a5049);
    runRound(fipsToState(128'h193de3bea0f4e22b9ac68d2ae9f84808),
             fipsToState(128'ha0fafe1788542cb123a339392a6c7605), 1'b0, 1'b0, 1'b0, res, cyc);
    randMode = 1'b0;
    checks++; if (res !== exp) $display("[TB] FAIL bfm_out got %h want %h", res, exp); else passes++;
    checks++; if (stableErr - se0 !== 0) $display("[TB] FAIL bfm_stable violations %0d want 0", stableErr - se0); else passes++;
    checks++; if (hsCount - hs0 !== 8) $display("[TB] FAIL bfm_handshakes got %0d want 8", hsCount - hs0); else passes++;
  endtask

  task automatic test_start_ignored();
    logic [127:0] res, exp;
    int cyc;
    exp = fipsToState(128'h3925841d02dc09fbdc118597196a0b32);
    runRound(fipsToState(128'heb40f21e592e38848ba113e71bc342d2),
             fipsToState(128'hd014f9a8c9ee2589e13f0cc8b6630ca6), 1'b0, 1'b1, 1'b1, res, cyc);
    checks++; if (res !== exp) $display("[TB] FAIL busy_start_out got %h want %h", res, exp); else passes++;
  endtask

  task automatic test_ready_idle();
    logic [127:0] prevOut;
    prevOut = state_out;
    @(negedge g_clk); junkReady = 1'b1;
    repeat (3) @(posedge g_clk);
    #1; junkReady = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL idle_ready_busy got %0b want 0", busy); else passes++;
    checks++; if (state_out !== prevOut) $display("[TB] FAIL idle_ready_out got %h want %h", state_out, prevOut); else passes++;
  endtask

  task automatic test_reset_midround();
    logic [127:0] res, exp;
    int cyc, dn0;
    dn0 = doneCount;
    @(negedge g_clk);
    state_in = fipsToState(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    rkey = fipsToState(128'ha0fafe1788542cb123a339392a6c7605);
    dec = 1'b0; last = 1'b0; start = 1'b1;
    @(posedge g_clk); #1; start = 1'b0;
    repeat (9) @(posedge g_clk);
    #1; g_resetn = 1'b0;
    @(posedge g_clk); #1;
    checks++; if (fu_valid !== 1'b0) $display("[TB] FAIL midrst_valid got %0b want 0", fu_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy got %0b want 0", busy); else passes++;
    checks++; if (state_out !== '0) $display("[TB] FAIL midrst_out got %h want 0", state_out); else passes++;
    g_resetn = 1'b1;
    repeat (2) @(posedge g_clk);
    #1;
    checks++; if (doneCount - dn0 !== 0) $display("[TB] FAIL midrst_done pulses %0d want 0", doneCount - dn0); else passes++;
    exp = fipsToState(128'ha49c7ff2689f352b6b5bea43026a5049);
    runRound(fipsToState(128'h193de3bea0f4e22b9ac68d2ae9f84808),
             fipsToState(128'ha0fafe1788542cb123a339392a6c7605), 1'b0, 1'b0, 1'b0, res, cyc);
    checks++; if (res !== exp) $display("[TB] FAIL midrst_rerun_out got %h want %h", res, exp); else passes++;
  endtask

  task automatic test_no_decrypt();
    logic [127:0] exp;
    int n, d1;
    d1 = decOneB;
    exp = fipsToState(128'ha49c7ff2689f352b6b5bea43026a5049);
    @(negedge g_clk);
    state_in = fipsToState(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    rkey = fipsToState(128'ha0fafe1788542cb123a339392a6c7605);
    dec = 1'b1; last = 1'b0; startB = 1'b1;
    @(posedge g_clk); #1; startB = 1'b0;
    n = 1;
    while (!doneB && n < 300) begin
      @(posedge g_clk); #1;
      n++;
    end
    checks++; if (doneB !== 1'b1) $display("[TB] FAIL noenc_complete done=%0b want 1", doneB); else passes++;
    checks++; if (stateOutB !== exp) $display("[TB] FAIL noenc_out got %h want %h", stateOutB, exp); else passes++;
    checks++; if (decOneB - d1 !== 0) $display("[TB] FAIL noenc_fu_dec high cycles %0d want 0", decOneB - d1); else passes++;
    @(posedge g_clk); #1;
    checks++; if (busyB !== 1'b0) $display("[TB] FAIL noenc_idle busy=%0b want 0", busyB); else passes++;
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_encrypt_last();
    test_decrypt_last();
    test_decrypt_zero();
    test_encrypt_zero();
    test_protocol();
    test_start_ignored();
    test_ready_idle();
    test_reset_midround();
    test_no_decrypt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
Initiator-side sequencer that drives the AES functional unit (SubBytes/MixColumns FU, valid/ready handshake, 32-bit rs1/rd) to compute one complete AES round on a 128-bit state.
- Issues four SubBytes column ops, then four MixColumns column ops (skipped on last round).
- Performs ShiftRows/InvShiftRows and AddRoundKey internally.
- Sits between the round-key/state datapath and one FU instance.

Parameters:
DECRYPT_EN, 1, when 0 the dec input is forced to 0 (encrypt only); fu_dec then ties to 0.

Ports:
g_clk  in  1  clock
g_resetn  in  1  reset, synchronous, active-low
start  in  1  request one round; sampled only while busy=0
dec  in  1  0 = encrypt round, 1 = decrypt round; sampled with start
last  in  1  final round (no MixColumns); sampled with start
state_in  in  128  input state; column c = bits 32c+31:32c; row r byte = bits 8r+7:8r within a column
rkey  in  128  round key, same layout; sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; state_out valid from this cycle
state_out  out  128  result register; holds until the next accepted start
fu_valid  out  1  FU request valid
fu_dec  out  1  FU decrypt select (registered dec)
fu_mix  out  1  FU op: 0 = SubBytes, 1 = MixColumns
fu_rs1  out  32  FU operand = current column of working state
fu_ready  in  1  FU result valid this cycle
fu_rd  in  32  FU result

Behaviour:
- Reset: FSM=IDLE, col=0; busy, done, fu_valid, fu_mix, fu_dec = 0; state_out and working regs = 0. Reset mid-round aborts immediately, no done pulse, fu_valid low the next cycle.
- FSM states: IDLE, SB, MC, FIN.
- IDLE:
  - On start: capture state_in into the working state, plus rkey, dec & DECRYPT_EN, and last.
  - Set col=0 and go to SB.
  - start while busy=1 is ignored, including in the FIN cycle.
- SB:
  - fu_valid=1, fu_mix=0, fu_rs1=work[col].
  - On fu_ready: work[col] <= fu_rd, col++.
  - On fu_ready with col==3, from the post-write state:
    - Encrypt: apply ShiftRows. If last, XOR rkey and go to FIN; else go to MC.
    - Decrypt: apply InvShiftRows, then XOR rkey. If last, go to FIN; else go to MC.
- MC:
  - fu_valid=1, fu_mix=1, fu_rs1=work[col].
  - On fu_ready: work[col] <= fu_rd, col++.
  - On col==3 ready: encrypt XORs rkey; decrypt applies no key. Go to FIN.
- FIN: state_out <= working state is loaded on the transition into FIN. done=1 for this cycle, then IDLE.
- ShiftRows: out[r][c] = in[r][(c+r) mod 4]. InvShiftRows: out[r][c] = in[r][(c-r) mod 4].
- Handshake:
  - fu_valid, fu_mix, fu_dec and fu_rs1 are held stable from assertion until the cycle fu_ready=1.
  - fu_valid stays high across consecutive ops; the operand changes the cycle after ready.
  - fu_ready while fu_valid=0 is ignored.
  - There is no timeout; latency is whatever the FU takes.
- fu_valid is never high in IDLE or FIN, which guarantees the FU returns to idle between rounds.
- Latency with the single-SBox FU (ready 4 cycles after valid for SubBytes, same cycle for MixColumns), start accepted at cycle 0:
  - SB occupies cycles 1-20, MC cycles 21-24, done at cycle 25.
  - Last round: done at cycle 21.
- col is 2 bits and wraps 3->0 on phase change.

Decomposition:
- Shared package aes_pkg: FSM state encoding, column/byte index helpers, and shift_rows/inv_shift_rows functions. These are also used by the future full-cipher controller.
- No sub-module; the FU is instantiated by the parent, not inside this block.

Test Plan:
- Encrypt, last=0, state_in=193de3bea0f4e22b9ac68d2ae9f84808 (byte 0 in bits 7:0), rkey=a0fafe1788542cb123a339392a6c7605 -> state_out=a49c7ff2689f352b6b5bea43026a5049, done at cycle 25, exactly 8 fu_ready handshakes.
- Encrypt, last=1, state_in=eb40f21e592e38848ba113e71bc342d2, rkey=d014f9a8c9ee2589e13f0cc8b6630ca6 -> 3925841d02dc09fbdc118597196a0b32, done at cycle 21, fu_mix never 1.
- Decrypt, last=1, rkey=0, state_in=e9317db5cb322c723d2e895faf090794 -> eb40f21e592e38848ba113e71bc342d2; fu_dec=1 throughout. Decrypt, last=0, all-zero in/key -> every byte 52. Encrypt, last=0, all-zero -> every byte 63.
- Protocol: replace the FU with a BFM inserting 0-7 random ready delays; assert operands are stable while valid&&!ready and results are identical to the first test. start pulsed while busy -> ignored, state_out unchanged until done.
- Reset: deassert g_resetn at cycle 10 of a round -> next cycle fu_valid=0, busy=0, state_out=0, no done. A new start then completes correctly.
- DECRYPT_EN=0, dec=1 -> fu_dec=0 and the output equals the encrypt result.
